mul_div_unit: RTL and testbench

- Parameterised iterative multiply/divide unit beside the single-cycle integer ALU in the EX stage.
- Executes signed and unsigned multiply and divide on WIDTH-bit operands over multiple cycles.
- Uses a start/busy/done handshake. Results sit in internal Hi/Lo registers.
- The pipeline control stalls on busy and reads Hi/Lo once done is seen.

---
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit.sv | 155 +++++++++++++++
 tb/tb_mul_div_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/result bundle for mul_div_unit.
//   master (issuer): drives start, MulOp, A, B; observes Hi, Lo, busy, done, div_zero
//   slave  (unit)  : the reverse
// A, B, Hi and Lo number bit 0 as the MSB.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       MulOp;     // [0]=1 divide, [1]=1 unsigned
  logic [0:WIDTH-1] A;
  logic [0:WIDTH-1] B;
  logic [0:WIDTH-1] Hi;
  logic [0:WIDTH-1] Lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, MulOp, A, B,
    input  Hi, Lo, busy, done, div_zero
  );

  modport slave (
    input  start, MulOp, A, B,
    output Hi, Lo, busy, done, div_zero
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and divide for the EX stage.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mul_div_unit_if.slave (start/MulOp/A/B in, Hi/Lo/busy/done/div_zero out)
// One radix-2 iteration per cycle on operand magnitudes, then one fix-up
// cycle applies signs and writes Hi/Lo. Latency is WIDTH+2 cycles from the
// start edge; done pulses for one cycle with the new Hi/Lo.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_div;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_op;       // multiplicand (mul) or divisor (div) magnitude
  logic [W2-1:0]    r_acc;      // mul: product:multiplier, div: remainder:quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  // Operand capture: sign and magnitude. The negation of the most-negative
  // value, read as unsigned, is exactly 2^(WIDTH-1), so WIDTH bits suffice.
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_a     = bus.A;
  assign w_b     = bus.B;
  assign w_a_neg = ~bus.MulOp[1] & w_a[WIDTH-1];
  assign w_b_neg = ~bus.MulOp[1] & w_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~w_a + WIDTH'(1)) : w_a;
  assign w_b_mag = w_b_neg ? (~w_b + WIDTH'(1)) : w_b;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  logic [WIDTH:0]  w_mul_sum;
  logic [W2-1:0]   w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_op} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring-division step: shift remainder:quotient left, trial-subtract
  // the divisor, keep the difference and set the quotient bit if non-negative.
  logic [WIDTH:0]   w_div_tmp;
  logic [WIDTH+1:0] w_div_diff;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_rem;
  logic [W2-1:0]    w_div_next;

  assign w_div_tmp  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff = {1'b0, w_div_tmp} - {2'b00, r_op};
  assign w_div_ok   = ~w_div_diff[WIDTH+1];
  assign w_div_rem  = w_div_ok ? WIDTH'(w_div_diff) : w_div_tmp[WIDTH-1:0];
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ok};

  // Sign fix-up. With a zero divisor every trial succeeds, so the quotient
  // is forced to all ones and the remainder already ends up equal to the
  // raw dividend (its magnitude re-signed like a normal remainder).
  logic             w_sgn_diff;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_sgn_diff = r_neg_a ^ r_neg_b;
  assign w_prod     = w_sgn_diff ? (~r_acc + W2'(1)) : r_acc;
  assign w_quo      = r_div_zero ? '1 :
                      (w_sgn_diff ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0]);
  assign w_rem      = r_neg_a ? (~r_acc[W2-1:WIDTH] + WIDTH'(1)) : r_acc[W2-1:WIDTH];

  // Control FSM and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_div      <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_op       <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_div      <= bus.MulOp[0];
            r_neg_a    <= w_a_neg;
            r_neg_b    <= w_b_neg;
            r_count    <= CNT_W'(WIDTH);
            r_div_zero <= bus.MulOp[0] & (w_b == '0);
            if (bus.MulOp[0]) begin
              r_op  <= w_b_mag;
              r_acc <= {WIDTH'(0), w_a_mag};
            end else begin
              r_op  <= w_a_mag;
              r_acc <= {WIDTH'(0), w_b_mag};
            end
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= r_div ? w_div_next : w_mul_next;
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[W2-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Hi       = r_hi;
  assign bus.Lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a WIDTH=32 unit tracked every cycle against an
// arithmetic reference with a start-to-done timeline, plus a WIDTH=8 unit
// checked with literal results.
module tb_mul_div_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W))  bus  ();
  mul_div_unit_if #(.WIDTH(W8)) bus8 ();

  mul_div_unit #(.WIDTH(W),  .CNT_W(6)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mul_div_unit #(.WIDTH(W8), .CNT_W(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference result from plain integer arithmetic.
  function automatic void model(input int unsigned w, input logic [1:0] op,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned hi, output longint unsigned lo);
    longint unsigned mask;
    longint sa, sb, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (!op[1] && a[w-1]) sa = sa - (longint'(1) << w);
    if (!op[1] && b[w-1]) sb = sb - (longint'(1) << w);
    if (!op[0]) begin
      p  = sa * sb;
      hi = longint'(unsigned'(p) >> w) & mask;
      lo = p & mask;
    end else if (b == 0) begin
      hi = a;
      lo = mask;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r & mask;
      lo = q & mask;
    end
  endfunction

  // Timeline model: an accepted request completes W+1 edges later.
  int unsigned     ecnt = 0;
  int unsigned     m_fin = 0;
  bit              m_act = 0, m_busy = 0, m_done = 0, m_dz = 0;
  longint unsigned m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

  always @(posedge clk) begin
    ecnt++;
    if (reset) begin
      m_act = 0; m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      if (m_act && ecnt == m_fin) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1; m_act = 0; m_busy = 0;
      end else if (!m_act && bus.start) begin
        model(W, bus.MulOp, longint'(bus.A), longint'(bus.B), p_hi, p_lo);
        m_dz   = bus.MulOp[0] && (bus.B == '0);
        m_act  = 1;
        m_busy = 1;
        m_fin  = ecnt + W + 1;
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     longint'(bus.busy),     longint'(m_busy));
      check("done",     longint'(bus.done),     longint'(m_done));
      check("div_zero", longint'(bus.div_zero), longint'(m_dz));
      check("hi",       longint'(bus.Hi),       m_hi);
      check("lo",       longint'(bus.Lo),       m_lo);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned t0);
    @(negedge clk);
    bus.start = 1'b1; bus.MulOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    t0 = ecnt;
    bus.start = 1'b0; bus.MulOp = 2'b11; bus.A = 32'hDEADBEEF; bus.B = 32'h0;
  endtask

  // Returns in the done cycle; latency counts that cycle, T0 is cycle 0.
  task automatic wait_done(input int unsigned t0, output int unsigned lat,
                           output int unsigned bc);
    bit got;
    got = 0;
    bc  = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.busy) bc++;
      @(negedge clk);
    end
    lat = ecnt - t0 + 1;
    check("done_seen", longint'(got), 1);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int unsigned t0, lat, bc;
    issue(op, a, b, t0);
    wait_done(t0, lat, bc);
    check({name, "_lat"}, longint'(lat), 34);
    check({name, "_hi"},  longint'(bus.Hi), longint'(ehi));
    check({name, "_lo"},  longint'(bus.Lo), longint'(elo));
  endtask

  initial begin
    int unsigned t0, lat, bc, nd;
    bit got;
    reset = 1'b1;
    bus.start  = 1'b0; bus.MulOp  = 2'b00; bus.A  = '0; bus.B  = '0;
    bus8.start = 1'b0; bus8.MulOp = 2'b00; bus8.A = '0; bus8.B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_hi",   longint'(bus.Hi),   0);
    check("rst_lo",   longint'(bus.Lo),   0);
    check("rst_dz",   longint'(bus.div_zero), 0);

    // signed -3 * 7, with busy-width check
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007, t0);
    wait_done(t0, lat, bc);
    check("smul_lat",  longint'(lat), 34);
    check("smul_busy", longint'(bc),  33);
    check("smul_hi",   longint'(bus.Hi), 64'hFFFFFFFF);
    check("smul_lo",   longint'(bus.Lo), 64'hFFFFFFEB);

    run("umul_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("smul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run("smul_mn", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run("sdiv",    2'b01, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("udiv",    2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);

    // divide by zero: flag from T0+1, raw dividend in Hi
    issue(2'b11, 32'h12345678, 32'h0, t0);
    check("dz_set", longint'(bus.div_zero), 1);
    wait_done(t0, lat, bc);
    check("dz_lat", longint'(lat), 34);
    check("dz_hi",  longint'(bus.Hi), 64'h12345678);
    check("dz_lo",  longint'(bus.Lo), 64'hFFFFFFFF);
    run("dz_neg", 2'b01, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // overflow divide with an ignored start mid-flight; also clears div_zero
    issue(2'b01, 32'h80000000, 32'hFFFFFFFF, t0);
    check("dz_clr", longint'(bus.div_zero), 0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.MulOp = 2'b10; bus.A = 32'h5; bus.B = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(t0, lat, bc);
    check("ovf_lat", longint'(lat), 34);
    check("ovf_hi",  longint'(bus.Hi), 64'h0);
    check("ovf_lo",  longint'(bus.Lo), 64'h80000000);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("ign_noqueue", longint'(nd), 0);

    // reset in the middle of a divide
    issue(2'b11, 32'h00000064, 32'h00000007, t0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", longint'(bus.busy), 0);
    check("mrst_hi",   longint'(bus.Hi),   0);
    check("mrst_lo",   longint'(bus.Lo),   0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("mrst_nodone", longint'(nd), 0);

    // start in the done cycle is accepted
    issue(2'b10, 32'h5, 32'h6, t0);
    wait_done(t0, lat, bc);
    check("sid_lo1", longint'(bus.Lo), 30);
    bus.start = 1'b1; bus.MulOp = 2'b00; bus.A = 32'hFFFFFFFE; bus.B = 32'hFFFFFFFE;
    @(negedge clk);
    t0 = ecnt;
    bus.start = 1'b0;
    check("sid_done1", longint'(bus.done), 0);
    check("sid_busy",  longint'(bus.busy), 1);
    wait_done(t0, lat, bc);
    check("sid_lat", longint'(lat), 34);
    check("sid_hi",  longint'(bus.Hi), 0);
    check("sid_lo",  longint'(bus.Lo), 4);

    // WIDTH=8 instance: -3 * 7
    @(negedge clk);
    bus8.start = 1'b1; bus8.MulOp = 2'b00; bus8.A = 8'hFD; bus8.B = 8'h07;
    @(negedge clk);
    t0 = ecnt;
    bus8.start = 1'b0; bus8.A = 8'h55; bus8.B = 8'hAA;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    lat = ecnt - t0 + 1;
    check("w8_done", longint'(got), 1);
    check("w8_lat",  longint'(lat), 10);
    check("w8_hi",   longint'(bus8.Hi), 64'hFF);
    check("w8_lo",   longint'(bus8.Lo), 64'hEB);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
